// File: rtl/lcd_refresh_scheduler.sv
// Character buffer for the hd44780 driver: arbitrates two writers, freezes the
// buffer while a print runs, and paces refresh triggers.
module lcd_refresh_scheduler #(
  parameter int unsigned       ADDR_W       = 6,
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       MIN_INTERVAL = 25000,
  parameter int unsigned       BUSY_TIMEOUT = 8,
  parameter logic [DATA_W-1:0] FILL_CHAR    = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              force_refresh,
  input  logic              lcd_busy,
  output logic              lcd_trg,
  input  logic [ADDR_W-1:0] lcd_addr,
  output logic [DATA_W-1:0] lcd_data,
  output logic              dirty,
  output logic              trg_err
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam int unsigned       CTR_W    = $clog2(MIN_INTERVAL + 1);
  localparam int unsigned       TMO_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CTR_W-1:0]  CTR_MAX  = CTR_W'(MIN_INTERVAL);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {CLEAR, IDLE, TRIGGER, WAIT_BUSY, PRINT} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   sweep_ptr;
  logic [CTR_W-1:0]    ctr;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                rr;
  logic                force_pend;
  logic                grant0, grant1;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                sweep_last, ctr_sat, timeout;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign sweep_last = (sweep_ptr == '1);
  assign ctr_sat    = (ctr == CTR_MAX);
  assign timeout    = (state == WAIT_BUSY) && !lcd_busy && (tmo_cnt == TMO_LAST);

  // Round-robin only matters when both requesters collide; rr names the favoured one.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = req0_valid && (!req1_valid || !rr);
      grant1 = req1_valid && (!req0_valid || rr);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    lcd_trg    = 1'b0;
    case (state)
      CLEAR:     if (sweep_last) state_next = IDLE;
      IDLE:      if (!lcd_busy && dirty && (ctr_sat || force_pend)) state_next = TRIGGER;
      TRIGGER: begin
        lcd_trg    = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (lcd_busy)     state_next = PRINT;
        else if (timeout) state_next = IDLE;
      end
      PRINT:     if (!lcd_busy) state_next = IDLE;
      default:   state_next = CLEAR;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sweep_ptr;
    wr_data = FILL_CHAR;
    if (state == CLEAR) begin
      wr_en = 1'b1;
    end else if (grant0) begin
      wr_en   = 1'b1;
      wr_addr = req0_addr;
      wr_data = req0_data;
    end else if (grant1) begin
      wr_en   = 1'b1;
      wr_addr = req1_addr;
      wr_data = req1_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CLEAR;
      sweep_ptr  <= '0;
      ctr        <= CTR_MAX;
      tmo_cnt    <= '0;
      rr         <= 1'b0;
      force_pend <= 1'b0;
      dirty      <= 1'b0;
      trg_err    <= 1'b0;
    end else begin
      state <= state_next;

      if (state == CLEAR) sweep_ptr <= sweep_ptr + 1'b1;

      if (state == TRIGGER) ctr <= '0;
      else if (!ctr_sat)    ctr <= ctr + 1'b1;

      if (state == WAIT_BUSY) tmo_cnt <= tmo_cnt + 1'b1;
      else                    tmo_cnt <= '0;

      if (grant0)      rr <= 1'b1;
      else if (grant1) rr <= 1'b0;

      if (state == TRIGGER)   force_pend <= 1'b0;
      else if (force_refresh) force_pend <= 1'b1;

      // A forced refresh marks the buffer dirty at once, so it qualifies the next IDLE cycle.
      if (state == TRIGGER)
        dirty <= 1'b0;
      else if ((state == CLEAR && sweep_last) || grant0 || grant1 || force_refresh || timeout)
        dirty <= 1'b1;

      if (timeout) trg_err <= 1'b1;
    end
  end

  // NOTE: the array has no reset; the CLEAR sweep initialises every location instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port is independent of the write port; a same-address write returns old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lcd_data <= '0;
    else      lcd_data <= mem[lcd_addr];
  end

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Self-checking bench for lcd_refresh_scheduler: directed sequence with random
// data, a shadow buffer and refresh timing derived from the interval rules.
module tb_lcd_refresh_scheduler;

  localparam int          ADDR_W       = 6;
  localparam int          DATA_W       = 8;
  localparam int          MIN_INTERVAL = 25000;
  localparam int          BUSY_TIMEOUT = 8;
  localparam logic [7:0]  FILL         = 8'h20;
  localparam int          DEPTH        = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              force_refresh, lcd_busy, lcd_trg;
  logic [ADDR_W-1:0] lcd_addr;
  logic [DATA_W-1:0] lcd_data;
  logic              dirty, trg_err;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         trg_count = 0;
  int         last_trg_cyc = -1;
  logic [7:0] buf_model [DEPTH];
  bit         rr_model;

  lcd_refresh_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MIN_INTERVAL(MIN_INTERVAL),
    .BUSY_TIMEOUT(BUSY_TIMEOUT), .FILL_CHAR(FILL)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .force_refresh(force_refresh), .lcd_busy(lcd_busy), .lcd_trg(lcd_trg),
    .lcd_addr(lcd_addr), .lcd_data(lcd_data), .dirty(dirty), .trg_err(trg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every wait goes through tick so each trg pulse is counted with its cycle number.
  task automatic tick();
    @(negedge clk);
    if (lcd_trg === 1'b1) begin
      trg_count++;
      last_trg_cyc = cyc;
    end
  endtask

  task automatic wait_trg(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      seen = (lcd_trg === 1'b1);
    end
  endtask

  // Called at the negedge where rst is released; no grant for the whole sweep.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check({tag, "_ready0"}, 32'(req0_ready), 32'd0);
      check({tag, "_ready1"}, 32'(req1_ready), 32'd0);
      tick();
    end
    for (int i = 0; i < DEPTH; i++) buf_model[i] = FILL;
  endtask

  task automatic single_write(input bit who, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req0_valid = !who; req0_addr = a; req0_data = d;
    req1_valid = who;  req1_addr = a; req1_data = d;
    #1;
    check(who ? "solo_grant1" : "solo_grant0", 32'(who ? req1_ready : req0_ready), 32'd1);
    check(who ? "solo_other0" : "solo_other1", 32'(who ? req0_ready : req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    buf_model[a] = d;
    rr_model = !who;
  endtask

  initial begin
    bit                seen;
    int                exp_cyc, cnt0, t3;
    logic [ADDR_W-1:0] wa [6];
    logic              g0;

    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    force_refresh = 1'b0; lcd_busy = 1'b0; lcd_addr = '0;
    rr_model = 1'b0;
    repeat (3) tick();

    check("rst_trg",     32'(lcd_trg),    32'd0);
    check("rst_ready0",  32'(req0_ready), 32'd0);
    check("rst_ready1",  32'(req1_ready), 32'd0);
    check("rst_dirty",   32'(dirty),      32'd0);
    check("rst_trg_err", 32'(trg_err),    32'd0);
    check("rst_data",    32'(lcd_data),   32'd0);

    // Post-reset sweep with both requesters pushing: nothing may be granted.
    req0_valid = 1'b1; req0_addr = ADDR_W'($urandom); req0_data = DATA_W'($urandom);
    req1_valid = 1'b1; req1_addr = ADDR_W'($urandom); req1_data = DATA_W'($urandom);
    rst = 1'b1;
    sweep_check("sweep");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("sweep_dirty", 32'(dirty),   32'd1);
    check("sweep_trg0",  32'(lcd_trg), 32'd0);

    // Interval counter starts saturated, so the first idle cycle already decides a trigger.
    exp_cyc = cyc + 1;
    wait_trg(10, seen);
    check("first_trg_seen", 32'(seen), 32'd1);
    check("first_trg_cyc",  32'(last_trg_cyc), 32'(exp_cyc));
    lcd_busy = 1'b1;
    tick();
    check("trg_one_cycle",     32'(lcd_trg), 32'd0);
    check("dirty_cleared_trg", 32'(dirty),   32'd0);

    // Buffer readback during the print; a pending write must stay blocked.
    req0_valid = 1'b1; req0_addr = 6'd5; req0_data = 8'h99;
    for (int a = 0; a < DEPTH; a++) begin
      lcd_addr = ADDR_W'(a);
      #1;
      check("print_ready0", 32'(req0_ready), 32'd0);
      tick();
      check("sweep_fill", 32'(lcd_data), 32'(buf_model[a]));
    end
    req0_valid = 1'b0;
    lcd_busy = 1'b0;
    tick();

    // Single-requester writes to random locations, last one from requester 1.
    for (int k = 0; k < 6; k++) begin
      wa[k] = ADDR_W'($urandom);
      single_write((k == 5) ? 1'b1 : 1'($urandom), wa[k], DATA_W'($urandom));
    end

    // Both valid and held: grants alternate starting from requester 0.
    req0_valid = 1'b1; req0_addr = 6'd5; req0_data = 8'h41;
    req1_valid = 1'b1; req1_addr = 6'd6; req1_data = 8'h42;
    for (int i = 0; i < 4; i++) begin
      #1;
      g0 = !rr_model;
      check("both_grant_seq", 32'(g0), 32'((i % 2) == 0));
      check("both_ready0", 32'(req0_ready), 32'(g0));
      check("both_ready1", 32'(req1_ready), 32'(!g0));
      tick();
      if (g0) buf_model[5] = 8'h41; else buf_model[6] = 8'h42;
      rr_model = g0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lcd_addr = 6'd5;
    tick();
    check("read_addr5", 32'(lcd_data), 32'h41);
    lcd_addr = 6'd6;
    tick();
    check("read_addr6", 32'(lcd_data), 32'h42);
    for (int k = 0; k < 6; k++) begin
      lcd_addr = wa[k];
      tick();
      check("read_random", 32'(lcd_data), 32'(buf_model[wa[k]]));
    end

    // Read and write the same address in one cycle: old data comes back first.
    lcd_addr = 6'd5;
    req0_valid = 1'b1; req0_addr = 6'd5; req0_data = 8'h5A;
    tick();
    req0_valid = 1'b0;
    check("raw_old_data", 32'(lcd_data), 32'(buf_model[5]));
    buf_model[5] = 8'h5A;
    tick();
    check("raw_new_data", 32'(lcd_data), 32'h5A);

    // Dirty buffer, counter cleared at the last trg: it reaches MIN_INTERVAL
    // MIN_INTERVAL+1 cycles after that trg, and the pulse follows one cycle later.
    check("dirty_before_interval", 32'(dirty), 32'd1);
    cnt0 = trg_count;
    exp_cyc = last_trg_cyc + MIN_INTERVAL + 2;
    wait_trg(MIN_INTERVAL + 100, seen);
    check("interval_trg_seen", 32'(seen), 32'd1);
    check("interval_trg_cyc",  32'(last_trg_cyc), 32'(exp_cyc));
    check("interval_trg_once", 32'(trg_count - cnt0), 32'd1);

    // Normal print, then back to idle with ctr = 10 and a clean buffer.
    lcd_busy = 1'b1;
    repeat (9) tick();
    lcd_busy = 1'b0;
    repeat (2) tick();
    check("clean_before_force", 32'(dirty), 32'd0);
    check("no_extra_trg",       32'(trg_count - cnt0), 32'd1);
    force_refresh = 1'b1;
    exp_cyc = cyc + 2;
    tick();
    force_refresh = 1'b0;
    wait_trg(6, seen);
    check("force_trg_seen", 32'(seen), 32'd1);
    check("force_trg_cyc",  32'(last_trg_cyc), 32'(exp_cyc));

    // Force while the driver is busy: deferred until lcd_busy falls.
    lcd_busy = 1'b1;
    repeat (3) tick();
    force_refresh = 1'b1;
    tick();
    force_refresh = 1'b0;
    cnt0 = trg_count;
    repeat (20) tick();
    check("busy_defers_trg", 32'(trg_count), 32'(cnt0));
    lcd_busy = 1'b0;
    exp_cyc = cyc + 2;
    wait_trg(6, seen);
    check("deferred_trg_seen", 32'(seen), 32'd1);
    check("deferred_trg_cyc",  32'(last_trg_cyc), 32'(exp_cyc));

    // Driver never answers: error after BUSY_TIMEOUT waiting cycles, then a retry.
    t3 = last_trg_cyc;
    repeat (BUSY_TIMEOUT) tick();
    check("tmo_err_not_yet",   32'(trg_err), 32'd0);
    check("tmo_dirty_not_yet", 32'(dirty),   32'd0);
    tick();
    check("tmo_err_set",   32'(trg_err), 32'd1);
    check("tmo_dirty_set", 32'(dirty),   32'd1);
    exp_cyc = t3 + MIN_INTERVAL + 2;
    wait_trg(MIN_INTERVAL + 100, seen);
    check("retry_trg_seen", 32'(seen), 32'd1);
    check("retry_trg_cyc",  32'(last_trg_cyc), 32'(exp_cyc));
    check("trg_err_sticky", 32'(trg_err), 32'd1);

    // Asynchronous reset in the middle of a print.
    lcd_busy = 1'b1;
    repeat (2) tick();
    req0_valid = 1'b1; req0_addr = 6'd9; req0_data = DATA_W'($urandom);
    #1;
    check("print_blocks_req", 32'(req0_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_trg",     32'(lcd_trg),    32'd0);
    check("arst_ready0",  32'(req0_ready), 32'd0);
    check("arst_trg_err", 32'(trg_err),    32'd0);
    check("arst_dirty",   32'(dirty),      32'd0);
    check("arst_data",    32'(lcd_data),   32'd0);
    tick();
    lcd_busy = 1'b0;
    rst = 1'b1;
    sweep_check("resweep");
    #1;
    check("resweep_grant", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0;
    lcd_addr = 6'd5;
    tick();
    check("resweep_fill", 32'(lcd_data), 32'(FILL));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
